dram_input_streamer: RTL and testbench

- Transmit side of the DRAM→IARAM compressed-activation stream.
- On a PE stream request, reads packed compressed activations (data plus indices) from backing DRAM, `LANES` elements per word.
- Presents them to I_OARAM as lane-masked beats under a valid/ready handshake.
- Signals completion to PE_CNTL with a one-cycle `Stream_input_finish_PE` pulse.

---
 rtl/dram_input_streamer.sv | 154 +++++++++++++++
 tb/tb_dram_input_streamer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_input_streamer.sv
// Streams packed compressed activations (data + index per lane) from DRAM to IARAM
// as lane-masked valid/ready beats, then pulses Stream_input_finish_PE once.
module dram_input_streamer #(
   parameter int LANES  = 4,
   parameter int DATA_W = 8,
   parameter int IDX_W  = 5,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ADDR_W-1:0]         req_base_addr,
   input  logic [CNT_W-1:0]          req_num_data,
   output logic                      mem_rd_en,
   output logic [ADDR_W-1:0]         mem_rd_addr,
   input  logic [LANES*(DATA_W+IDX_W)-1:0] mem_rd_data,
   output logic                      dram_beat_valid,
   input  logic                      iaram_ready,
   output logic [LANES*DATA_W-1:0]   dram_data,
   output logic [LANES*IDX_W-1:0]    dram_indices,
   output logic [LANES-1:0]          dram_lane_valid,
   output logic                      Stream_input_finish_PE,
   output logic                      busy
);

   localparam int LW   = DATA_W + IDX_W;
   localparam int LC_W = $clog2(LANES + 1);
   localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
   localparam logic [LC_W-1:0]  LANES_L = LC_W'(LANES);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg;
   logic [CNT_W-1:0]    rem_reg;
   logic                inflight_reg;
   logic [LC_W-1:0]     inflight_lanes_reg;
   logic [1:0]          count_reg, count_next;
   logic                wr_ptr_reg, rd_ptr_reg;

   logic [LANES*DATA_W-1:0] fifo_data [2];
   logic [LANES*IDX_W-1:0]  fifo_idx  [2];
   logic [LANES-1:0]        fifo_mask [2];

   logic                    rd_en, push, pop, credit_ok;
   logic [LC_W-1:0]         issue_lanes;
   logic [LANES-1:0]        push_mask;
   logic [LANES*DATA_W-1:0] push_data;
   logic [LANES*IDX_W-1:0]  push_idx;

   // Lanes carried by the word about to be read: full, or whatever is left of N.
   assign issue_lanes = (rem_reg >= LANES_C) ? LANES_L : rem_reg[LC_W-1:0];

   assign push            = inflight_reg;
   assign dram_beat_valid = (count_reg != 2'd0);
   assign pop             = dram_beat_valid & iaram_ready;
   assign count_next      = count_reg + {1'b0, push} - {1'b0, pop};
   // Words buffered plus the one in flight must leave room for the new read.
   assign credit_ok = ({1'b0, count_reg} + {2'b0, inflight_reg}) < (3'd2 + {2'b0, pop});

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [LW-1:0] lane_word;
         assign lane_word     = mem_rd_data[gi*LW +: LW];
         assign push_mask[gi] = (LC_W'(gi) < inflight_lanes_reg);
         assign push_data[gi*DATA_W +: DATA_W] = push_mask[gi] ? lane_word[DATA_W-1:0] : '0;
         assign push_idx[gi*IDX_W +: IDX_W]    = push_mask[gi] ? lane_word[LW-1:DATA_W] : '0;
      end
   endgenerate

   assign dram_data       = dram_beat_valid ? fifo_data[rd_ptr_reg] : '0;
   assign dram_indices    = dram_beat_valid ? fifo_idx[rd_ptr_reg]  : '0;
   assign dram_lane_valid = dram_beat_valid ? fifo_mask[rd_ptr_reg] : '0;
   assign mem_rd_en       = rd_en;
   assign mem_rd_addr     = addr_reg;

   always_comb begin
      state_next             = state_reg;
      rd_en                  = 1'b0;
      req_ready              = 1'b0;
      busy                   = 1'b1;
      Stream_input_finish_PE = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               state_next = (req_num_data == '0) ? FINISH : FETCH;
            end
         end
         FETCH: begin
            if (credit_ok) begin
               rd_en = 1'b1;
               if (rem_reg <= LANES_C) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (count_next == 2'd0) begin
               state_next = FINISH;
            end
         end
         FINISH: begin
            Stream_input_finish_PE = 1'b1;
            state_next             = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg          <= IDLE;
         addr_reg           <= '0;
         rem_reg            <= '0;
         inflight_reg       <= 1'b0;
         inflight_lanes_reg <= '0;
         count_reg          <= 2'd0;
         wr_ptr_reg         <= 1'b0;
         rd_ptr_reg         <= 1'b0;
      end else begin
         state_reg          <= state_next;
         inflight_reg       <= rd_en;
         inflight_lanes_reg <= issue_lanes;
         count_reg          <= count_next;
         if (state_reg == IDLE && req_valid) begin
            addr_reg <= req_base_addr;
            rem_reg  <= req_num_data;
         end else if (rd_en) begin
            addr_reg <= addr_reg + 1'b1;
            rem_reg  <= rem_reg - CNT_W'(issue_lanes);
         end
         if (push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
      end
   end

   // Storage carries no reset; occupancy and pointers decide what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr_reg] <= push_data;
         fifo_idx[wr_ptr_reg]  <= push_idx;
         fifo_mask[wr_ptr_reg] <= push_mask;
      end
   end

endmodule

// File: tb/tb_dram_input_streamer.sv
// Directed bench for dram_input_streamer: cycle-exact latency, lane masks,
// stalls, N=0, mid-stream reset and requests ignored while busy.
module tb_dram_input_streamer;

   localparam int LANES  = 4;
   localparam int DATA_W = 8;
   localparam int IDX_W  = 5;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = 10;
   localparam int LW     = DATA_W + IDX_W;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic                      req_valid = 1'b0;
   logic                      req_ready;
   logic [ADDR_W-1:0]         req_base_addr = '0;
   logic [CNT_W-1:0]          req_num_data = '0;
   logic                      mem_rd_en;
   logic [ADDR_W-1:0]         mem_rd_addr;
   logic [LANES*LW-1:0]       mem_rd_data = '0;
   logic                      dram_beat_valid;
   logic                      iaram_ready = 1'b1;
   logic [LANES*DATA_W-1:0]   dram_data;
   logic [LANES*IDX_W-1:0]    dram_indices;
   logic [LANES-1:0]          dram_lane_valid;
   logic                      Stream_input_finish_PE;
   logic                      busy;

   dram_input_streamer #(
      .LANES(LANES), .DATA_W(DATA_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_base_addr(req_base_addr), .req_num_data(req_num_data),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .dram_beat_valid(dram_beat_valid), .iaram_ready(iaram_ready),
      .dram_data(dram_data), .dram_indices(dram_indices), .dram_lane_valid(dram_lane_valid),
      .Stream_input_finish_PE(Stream_input_finish_PE), .busy(busy)
   );

   always #5 clk = ~clk;

   int total_cnt = 0;
   int bad_cnt   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Backing DRAM: lane i of word a holds data=(4a+i), idx=(a+i) mod 32.
   logic [LANES*LW-1:0] mem [1024];

   function automatic logic [LANES*LW-1:0] word_of(input int a);
      logic [LANES*LW-1:0] w;
      w = '0;
      for (int i = 0; i < LANES; i++) begin
         w[i*LW +: DATA_W]      = DATA_W'(4 * a + i);
         w[i*LW + DATA_W +: IDX_W] = IDX_W'(a + i);
      end
      return w;
   endfunction

   function automatic logic [LANES*DATA_W-1:0] word_d(input logic [LANES*LW-1:0] w);
      logic [LANES*DATA_W-1:0] d;
      for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = w[i*LW +: DATA_W];
      return d;
   endfunction

   function automatic logic [LANES*IDX_W-1:0] word_i(input logic [LANES*LW-1:0] w);
      logic [LANES*IDX_W-1:0] x;
      for (int i = 0; i < LANES; i++) x[i*IDX_W +: IDX_W] = w[i*LW + DATA_W +: IDX_W];
      return x;
   endfunction

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   // Monitor: collects handshaked beats, finish pulses and outstanding-word high-water mark.
   logic [LANES*DATA_W-1:0] q_data [$];
   logic [LANES*IDX_W-1:0]  q_idx  [$];
   logic [LANES-1:0]        q_mask [$];
   int fin_cnt = 0, issued = 0, popped = 0, max_out = 0;

   always @(posedge clk) begin
      if (!rst) begin
         if (mem_rd_en) issued++;
         if (Stream_input_finish_PE) fin_cnt++;
         if (dram_beat_valid && iaram_ready) begin
            popped++;
            q_data.push_back(dram_data);
            q_idx.push_back(dram_indices);
            q_mask.push_back(dram_lane_valid);
            $display("beat %0d: data=%h idx=%h mask=%b", q_data.size() - 1,
                     dram_data, dram_indices, dram_lane_valid);
         end
      end
   end

   always @(negedge clk) begin
      int o;
      o = issued + int'(mem_rd_en) - popped - int'(dram_beat_valid && iaram_ready);
      if (o > max_out) max_out = o;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      q_data.delete();
      q_idx.delete();
      q_mask.delete();
      fin_cnt = 0;
      issued  = 0;
      popped  = 0;
      max_out = 0;
   endtask

   // Present a request for one cycle; returns in cycle T+1 (first read cycle).
   task automatic send_req(input int base, input int n);
      req_valid     = 1'b1;
      req_base_addr = ADDR_W'(base);
      req_num_data  = CNT_W'(n);
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_finish(input int budget, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (Stream_input_finish_PE) begin
            seen = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic check_full_beats(input string tag, input int base, input int nb);
      check({tag, "_nbeats"}, 64'(q_data.size()), 64'(nb));
      for (int k = 0; k < nb && k < q_data.size(); k++) begin
         check($sformatf("%s_d%0d", tag, k), 64'(q_data[k]), 64'(word_d(word_of(base + k))));
         check($sformatf("%s_i%0d", tag, k), 64'(q_idx[k]),  64'(word_i(word_of(base + k))));
         check($sformatf("%s_m%0d", tag, k), 64'(q_mask[k]), 64'(4'b1111));
      end
   endtask

   initial begin
      bit seen;
      logic [LANES*DATA_W-1:0] h_data;
      logic [LANES*IDX_W-1:0]  h_idx;
      logic [LANES-1:0]        h_mask;

      for (int a = 0; a < 1024; a++) mem[a] = word_of(a);
      // Words 0x20/0x21: lane i holds data=i, idx=i+1.
      for (int a = 32; a < 34; a++) begin
         for (int i = 0; i < LANES; i++) begin
            mem[a][i*LW +: DATA_W]         = DATA_W'(i);
            mem[a][i*LW + DATA_W +: IDX_W] = IDX_W'(i + 1);
         end
      end

      // Reset state
      step(); step();
      check("rst_req_ready", 64'(req_ready), 64'(1));
      check("rst_rd_en", 64'(mem_rd_en), 64'(0));
      check("rst_rd_addr", 64'(mem_rd_addr), 64'(0));
      check("rst_valid", 64'(dram_beat_valid), 64'(0));
      check("rst_mask", 64'(dram_lane_valid), 64'(0));
      check("rst_finish", 64'(Stream_input_finish_PE), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      rst = 1'b0;
      step();
      clear_mon();

      // N=8 at 0x10: cycle-exact timeline
      send_req(16, 8);
      check("t1_rd0_en", 64'(mem_rd_en), 64'(1));
      check("t1_rd0_addr", 64'(mem_rd_addr), 64'h10);
      step();
      check("t1_rd1_en", 64'(mem_rd_en), 64'(1));
      check("t1_rd1_addr", 64'(mem_rd_addr), 64'h11);
      check("t1_t2_valid", 64'(dram_beat_valid), 64'(0));
      step();
      check("t1_b0_valid", 64'(dram_beat_valid), 64'(1));
      check("t1_b0_data", 64'(dram_data), 64'(word_d(word_of(16))));
      check("t1_t3_rd_en", 64'(mem_rd_en), 64'(0));
      step();
      check("t1_b1_valid", 64'(dram_beat_valid), 64'(1));
      check("t1_b1_mask", 64'(dram_lane_valid), 64'(4'b1111));
      check("t1_b1_data", 64'(dram_data), 64'(word_d(word_of(17))));
      step();
      check("t1_finish", 64'(Stream_input_finish_PE), 64'(1));
      check("t1_fin_req_ready", 64'(req_ready), 64'(0));
      check("t1_fin_valid", 64'(dram_beat_valid), 64'(0));
      step();
      check("t1_idle_ready", 64'(req_ready), 64'(1));
      check("t1_idle_finish", 64'(Stream_input_finish_PE), 64'(0));
      check_full_beats("t1", 16, 2);
      clear_mon();

      // N=6 at 0x20: partial last beat, hand-computed values
      send_req(32, 6);
      wait_finish(40, seen);
      check("t2_finish_seen", 64'(seen), 64'(1));
      step();
      check("t2_fin_cnt", 64'(fin_cnt), 64'(1));
      check("t2_nbeats", 64'(q_data.size()), 64'(2));
      check("t2_b0_mask", 64'(q_mask[0]), 64'(4'b1111));
      check("t2_b0_data", 64'(q_data[0]), 64'h03020100);
      check("t2_b0_idx", 64'(q_idx[0]), 64'h20C41);
      check("t2_b1_mask", 64'(q_mask[1]), 64'(4'b0011));
      check("t2_b1_data", 64'(q_data[1]), 64'h00000100);
      check("t2_b1_idx", 64'(q_idx[1]), 64'h041);
      clear_mon();

      // N=0: immediate finish, no traffic
      send_req(5, 0);
      check("t3_finish", 64'(Stream_input_finish_PE), 64'(1));
      check("t3_req_ready_lo", 64'(req_ready), 64'(0));
      check("t3_rd_en", 64'(mem_rd_en), 64'(0));
      step();
      check("t3_req_ready", 64'(req_ready), 64'(1));
      check("t3_fin_off", 64'(Stream_input_finish_PE), 64'(0));
      step();
      check("t3_reads", 64'(issued), 64'(0));
      check("t3_beats", 64'(q_data.size()), 64'(0));
      check("t3_fin_cnt", 64'(fin_cnt), 64'(1));
      clear_mon();

      // N=16 at 0x40 with a 3-cycle IARAM stall on beat 1
      send_req(64, 16);
      step();
      step();
      step();
      iaram_ready = 1'b0;
      check("t4_hold_valid0", 64'(dram_beat_valid), 64'(1));
      h_data = dram_data;
      h_idx  = dram_indices;
      h_mask = dram_lane_valid;
      for (int c = 1; c <= 3; c++) begin
         step();
         check($sformatf("t4_hold_valid%0d", c), 64'(dram_beat_valid), 64'(1));
         check($sformatf("t4_hold_data%0d", c), 64'(dram_data), 64'(h_data));
         check($sformatf("t4_hold_idx%0d", c), 64'(dram_indices), 64'(h_idx));
         check($sformatf("t4_hold_mask%0d", c), 64'(dram_lane_valid), 64'(h_mask));
      end
      iaram_ready = 1'b1;
      wait_finish(60, seen);
      check("t4_finish_seen", 64'(seen), 64'(1));
      step();
      check_full_beats("t4", 64, 4);
      check("t4_outstanding_le2", 64'(max_out <= 2), 64'(1));
      check("t4_reads", 64'(issued), 64'(4));
      clear_mon();

      // Reset during beat 1 of N=16 at 0x80, then N=4 at 0x90
      send_req(128, 16);
      step();
      step();
      step();
      rst = 1'b1;
      step();
      check("t5_req_ready", 64'(req_ready), 64'(1));
      check("t5_rd_en", 64'(mem_rd_en), 64'(0));
      check("t5_rd_addr", 64'(mem_rd_addr), 64'(0));
      check("t5_valid", 64'(dram_beat_valid), 64'(0));
      check("t5_data", 64'(dram_data), 64'(0));
      check("t5_idx", 64'(dram_indices), 64'(0));
      check("t5_mask", 64'(dram_lane_valid), 64'(0));
      check("t5_finish", 64'(Stream_input_finish_PE), 64'(0));
      check("t5_busy", 64'(busy), 64'(0));
      rst = 1'b0;
      step();
      check("t5_post_valid", 64'(dram_beat_valid), 64'(0));
      check("t5_post_finish", 64'(Stream_input_finish_PE), 64'(0));
      clear_mon();
      send_req(144, 4);
      wait_finish(40, seen);
      check("t5_finish_seen", 64'(seen), 64'(1));
      step();
      check_full_beats("t5", 144, 1);
      check("t5_fin_cnt", 64'(fin_cnt), 64'(1));
      clear_mon();

      // N=8 at 0x30 with req_valid pulsed during DRAIN
      send_req(48, 8);
      step();
      step();
      check("t6_busy_drain", 64'(busy), 64'(1));
      req_valid     = 1'b1;
      req_base_addr = ADDR_W'(512);
      req_num_data  = CNT_W'(5);
      step();
      step();
      req_valid = 1'b0;
      for (int c = 0; c < 15; c++) step();
      check("t6_fin_cnt", 64'(fin_cnt), 64'(1));
      check("t6_reads", 64'(issued), 64'(2));
      check_full_beats("t6", 48, 2);
      check("t6_idle", 64'(req_ready), 64'(1));

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
